// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring-divide unit with a start/done handshake.
// The divide datapath is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        mag_a_d   = mag_a_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        accept  = start && (state_q == S_IDLE || state_q == S_DONE);
        a_neg   = op[0] & a[WIDTH-1];
        b_neg   = op[0] & b[WIDTH-1];
        a_abs   = a_neg ? -a : a;
        b_abs   = b_neg ? -b : b;
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
        prod    = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_DIV_EN
        mag_b_d   = mag_b_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    cnt_d     = '0;
                    div_d     = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    mag_a_d   = a_abs;
                    acc_hi_d  = '0;
                    acc_lo_d  = op[1] ? a_abs : b_abs;
                    state_d   = S_CALC;
`ifdef MULDIV_DIV_EN
                    mag_b_d   = b_abs;
                    neg_rem_d = a_neg;
                    dbz_d     = op[1] && (b == '0);
                    // Divide by zero keeps the raw dividend for the HI result.
                    if (dbz_d) begin
                        mag_a_d = a;
                        state_d = S_FIX;
                    end
`else
                    if (op[1]) state_d = S_FIX;
`endif
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else
`endif
                begin
                    // The add carry becomes the new top bit as {P,Q} shifts right.
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end

            S_FIX: begin
                state_d = S_DONE;
`ifdef MULDIV_DIV_EN
                if (div_q) begin
                    if (dbz_q) begin
                        hi_d = mag_a_q;
                        lo_d = '1;
                    end else begin
                        lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                    end
                end else
`else
                if (div_q) begin
                    hi_d = '0;
                    lo_d = '0;
                end else
`endif
                begin
                    {hi_d, lo_d} = neg_res_q ? -prod : prod;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            mag_a_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef MULDIV_DIV_EN
            mag_b_q   <= '0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            mag_a_q   <= mag_a_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
`ifdef MULDIV_DIV_EN
            mag_b_q   <= mag_b_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the multi-cycle CPU. It accepts two operands and an opcode with a start/done handshake and runs a radix-2 shift-add or restoring-divide loop for 32 cycles. It returns the 64-bit result in registered HI/LO outputs. The control FSM stalls on `busy` and collects HI/LO when `done` pulses; the unit then sits idle until the next start.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits. Only 32 is verified.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE or DONE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: multiplicand or dividend; captured on accepted start.
- `b` in 32: multiplier or divisor; captured on accepted start.
- `busy` out 1: high in CALC and FIX.
- `done` out 1: one-cycle pulse, high exactly in DONE.
- `hi` out 32: product[63:32] or remainder; holds until next DONE.
- `lo` out 32: product[31:0] or quotient; holds until next DONE.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state=IDLE, counter=0, internal regs=0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- **IDLE or DONE with `start`=1:**
  - Latch `op`.
  - Latch magnitudes of `a` and `b`. Two's-complement absolute value applies only for op 01 and 11.
  - Latch the result sign flags.
  - Clear counter; go to CALC.
- **Start while busy:** ignored, no side effects.
- **Divide by zero (op 1x, `b`=0):** detected at start; skip CALC and go directly to FIX.
- **CALC, multiply:** 64-bit accumulator {P,Q}, Q initialised to |b|. Each cycle, add |a| to the upper half when Q[0]=1, then shift right 1. The 33-bit add carry shifts in.
- **CALC, divide:** restoring division. Each cycle:
  - Shift {R,Q} left 1.
  - Trial-subtract |b| from R.
  - Keep the result and set Q[0]=1 if it is non-negative.
- **CALC exit:** counter increments each cycle; after counter=31, go to FIX.
- **FIX, signed multiply:** negate the 64-bit product if signs differ.
- **FIX, signed divide:**
  - Negate the quotient if the signs of a and b differ.
  - Negate the remainder if a was negative.
  - Quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- **FIX, divide by zero:** lo=0xFFFFFFFF, hi=original `a`.
- **FIX → DONE:** `hi`/`lo` registered on the FIX→DONE edge.
- **DONE:** `done`=1 for one cycle, then IDLE, unless `start`=1, which goes to CALC (or FIX for divide by zero).
- **Mid-operation reset:** immediately returns to IDLE with all outputs 0. No partial result appears.

## Timing
- Start sampled at edge E0.
- CALC occupies E1..E32. The state is CALC after E0, through E31.
- FIX applies at E33. `done`=1 and `hi`/`lo` valid in the cycle after E33.
- Latency from the start edge to the `done` cycle is 34 clocks. Divide by zero takes 2 clocks (FIX, then DONE).
- `busy` is high the cycle after E0 through FIX and low during DONE.
- Back-to-back throughput: start asserted during DONE restarts with zero idle cycles.
- `hi`/`lo` change only on the edge entering DONE, or on reset.

## Configuration
- **`MULDIV_DIV_EN` defined:** divide datapath (trial subtractor, remainder fixup, divide-by-zero path) is compiled in; behaviour as above.
- **`MULDIV_DIV_EN` undefined:**
  - Divide logic is removed.
  - op 10/11 go IDLE→FIX→DONE (2 cycles) with hi=0, lo=0.
  - Multiply is unchanged.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles -> `busy`=0, `done`=0, hi=0, lo=0.
- **MULTU / MULT:**
  - MULTU a=0xFFFFFFFF, b=2 -> done at cycle 34, hi=0x00000001, lo=0xFFFFFFFE.
  - MULT with the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- **DIVU / DIV:**
  - DIVU a=100, b=7 -> lo=14, hi=2.
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Divide by zero:** DIV a=0x12345678, b=0 -> `done` 2 cycles after start, lo=0xFFFFFFFF, hi=0x12345678.
  - Without `MULDIV_DIV_EN`: hi=lo=0 in 2 cycles.
- **Handshake:**
  - Start asserted again at cycle 10 of a MULTU -> ignored; result unchanged.
  - Start asserted during DONE -> next op's `done` arrives 34 cycles later.
- **Reset mid-op:** `rst_n`=0 at cycle 15 of a DIVU -> immediate IDLE, hi=lo=0, no `done` pulse.
